// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and counter sizing for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    function automatic int cnt_width(input int hold, input int stag, input int run);
        int m;
        m = hold;
        if (stag > m) m = stag;
        if (run > m) m = run;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/hold inputs and staggered reset outputs of the sequencer
interface reset_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              sw_req;
    logic              ext_hold;
    logic [NUM_CH-1:0] ch_reset_n;
    logic              all_released;
    logic              run_done;

    modport master (
        output sw_req, ext_hold,
        input  ch_reset_n, all_released, run_done
    );

    modport slave (
        input  sw_req, ext_hold,
        output ch_reset_n, all_released, run_done
    );
endinterface

// File: rtl/reset_seq_cnt.sv
// rtl/reset_seq_cnt.sv - loadable up-counter that saturates at its terminal value
module reset_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (en_i && (cnt_q != tc_val_i))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == tc_val_i);
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-channel reset release with optional run watchdog
// Optional feature: RESET_SEQ_WATCHDOG_EN enables the run-window counter and run_done.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int HOLD_CYCLES    = 5,
    parameter int STAGGER_CYCLES = 2,
    parameter int RUN_CYCLES     = 120
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, RUN_CYCLES);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_TC = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] RUN_TC  = CW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
`endif

    if (NUM_CH < 1 || NUM_CH > 32 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || RUN_CYCLES < 0)
    begin : g_param_err
        $error("reset_sequencer: parameter out of range");
    end

    seq_state_e        state_q;
    logic              started_q;
    logic [IW-1:0]     idx_q;
    logic [NUM_CH-1:0] ch_q;
    logic              all_rel_q;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic              run_done_q;
`endif

    logic          restart;
    logic          cnt_clr, cnt_load, cnt_en, cnt_tc;
    logic [CW-1:0] tc_val;

    assign restart = (state_q != ST_ASSERT) && bus.sw_req;

    // One counter serves every phase; each phase entry reloads it from zero.
    always_comb begin
        tc_val   = HOLD_TC;
        cnt_clr  = 1'b1;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (!restart && !bus.ext_hold) begin
                    cnt_clr  = 1'b0;
                    cnt_load = cnt_tc;
                    cnt_en   = !cnt_tc;
                end
            end
            ST_RELEASE: begin
                tc_val = STAG_TC;
                if (!restart) begin
                    cnt_clr  = 1'b0;
                    cnt_load = cnt_tc;
                    cnt_en   = !cnt_tc;
                end
            end
`ifdef RESET_SEQ_WATCHDOG_EN
            ST_RUN: begin
                tc_val = RUN_TC;
                if (!restart && (RUN_CYCLES != 0)) begin
                    cnt_clr  = 1'b0;
                    cnt_load = cnt_tc;
                    cnt_en   = !cnt_tc;
                end
            end
`endif
            default: ;
        endcase
    end

    reset_seq_cnt #(.W(CW)) u_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i ('0),
        .tc_val_i   (tc_val),
        .tc_o       (cnt_tc)
    );

    // started_q makes the first post-reset edge count as the single ASSERT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ASSERT;
            started_q  <= 1'b0;
            idx_q      <= '0;
            ch_q       <= '0;
            all_rel_q  <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
            run_done_q <= 1'b0;
`endif
        end else if (restart) begin
            state_q    <= ST_ASSERT;
            started_q  <= 1'b1;
            idx_q      <= '0;
            ch_q       <= '0;
            all_rel_q  <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
            run_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (started_q)
                        state_q <= ST_HOLD;
                    else
                        started_q <= 1'b1;
                end
                ST_HOLD: begin
                    if (!bus.ext_hold && cnt_tc) begin
                        ch_q[0] <= 1'b1;
                        idx_q   <= IW'(1);
                        if (NUM_CH == 1) begin
                            all_rel_q <= 1'b1;
                            state_q   <= ST_RUN;
                        end else begin
                            state_q   <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_tc) begin
                        ch_q[idx_q] <= 1'b1;
                        if (idx_q == LAST_CH) begin
                            all_rel_q <= 1'b1;
                            state_q   <= ST_RUN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
`ifdef RESET_SEQ_WATCHDOG_EN
                    if ((RUN_CYCLES != 0) && cnt_tc) begin
                        run_done_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
`endif
                end
                ST_DONE: ;
                default: state_q <= ST_ASSERT;
            endcase
        end
    end

    assign bus.ch_reset_n   = ch_q;
    assign bus.all_released = all_rel_q;
`ifdef RESET_SEQ_WATCHDOG_EN
    assign bus.run_done     = run_done_q;
`else
    assign bus.run_done     = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer output change events
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_CH(3)) ifa ();
    reset_sequencer_if #(.NUM_CH(1)) ifb ();

    reset_sequencer dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    reset_sequencer #(
        .NUM_CH         (1),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (1),
        .RUN_CYCLES     (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        int         cyc;
        logic [2:0] ch;
        logic       ar;
        logic       rd;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    function automatic ev_t mk(input int c, input logic [2:0] ch, input logic ar, input logic rd);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        e.ar  = ar;
        e.rd  = rd;
        return e;
    endfunction

    function automatic logic [4:0] obs(input bit sel);
        if (sel)
            return {2'b00, ifb.ch_reset_n, ifb.all_released, ifb.run_done};
        return {ifa.ch_reset_n, ifa.all_released, ifa.run_done};
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        ifa.sw_req   = 1'b0;
        ifa.ext_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // Cycle n input is applied before edge n; output seen after edge n belongs to cycle n+1.
    task automatic run_scn(input string name, input bit sel, input int ncyc,
                           input int rst_cyc, input int sw_cyc, input int eh_lo, input int eh_hi);
        logic [4:0] prev;
        logic [4:0] cur;
        logic [4:0] want;
        ev_t        e;
        prev = 5'b0;
        for (int n = 0; n < ncyc; n++) begin
            reset        = (n == rst_cyc);
            ifa.sw_req   = (n == sw_cyc);
            ifa.ext_hold = (n >= eh_lo) && (n <= eh_hi);
            @(posedge clk);
            @(negedge clk);
            cur = obs(sel);
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected change at cycle %0d: got ch/ar/rd=%b", name, n + 1, cur);
                end else begin
                    e    = exp_q.pop_front();
                    want = {e.ch, e.ar, e.rd};
                    if (((n + 1) !== e.cyc) || (cur !== want)) begin
                        bad++;
                        $display("FAIL %s event: got cycle %0d ch/ar/rd=%b, expected cycle %0d ch/ar/rd=%b",
                                 name, n + 1, cur, e.cyc, want);
                    end
                end
                prev = cur;
            end
        end
        reset        = 1'b0;
        ifa.sw_req   = 1'b0;
        ifa.ext_hold = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s missing event: expected cycle %0d ch/ar/rd=%b%b%b, not seen",
                     name, e.cyc, e.ch, e.ar, e.rd);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ifa.ch_reset_n !== 3'b000) begin
            bad++;
            $display("FAIL reset_ch_a got=%b expected=000", ifa.ch_reset_n);
        end
        total++;
        if (ifa.all_released !== 1'b0) begin
            bad++;
            $display("FAIL reset_ar_a got=%b expected=0", ifa.all_released);
        end
        total++;
        if (ifa.run_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_a got=%b expected=0", ifa.run_done);
        end
        total++;
        if (ifb.ch_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL reset_ch_b got=%b expected=0", ifb.ch_reset_n);
        end
        total++;
        if (ifb.all_released !== 1'b0) begin
            bad++;
            $display("FAIL reset_ar_b got=%b expected=0", ifb.all_released);
        end
        total++;
        if (ifb.run_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_b got=%b expected=0", ifb.run_done);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        exp_q.push_back(mk(7,  3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(9,  3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(11, 3'b111, 1'b1, 1'b0));
`ifdef RESET_SEQ_WATCHDOG_EN
        exp_q.push_back(mk(131, 3'b111, 1'b1, 1'b1));
`endif
        run_scn("nominal", 1'b0, 500, -1, -1, -1, -2);
    endtask

    task automatic test_ext_hold();
        do_reset();
        exp_q.push_back(mk(14, 3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(16, 3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(18, 3'b111, 1'b1, 1'b0));
        run_scn("ext_hold", 1'b0, 25, -1, -1, 4, 8);
    endtask

    task automatic test_ext_hold_ignored();
        do_reset();
        exp_q.push_back(mk(7,  3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(9,  3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(11, 3'b111, 1'b1, 1'b0));
        run_scn("ext_hold_ignored", 1'b0, 45, -1, -1, 7, 40);
    endtask

    task automatic test_sw_req();
        do_reset();
        exp_q.push_back(mk(7,  3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(9,  3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(11, 3'b000, 1'b0, 1'b0));
        exp_q.push_back(mk(17, 3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(19, 3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(21, 3'b111, 1'b1, 1'b0));
        run_scn("sw_req", 1'b0, 30, -1, 10, -1, -2);
    endtask

    task automatic test_reset_priority();
        do_reset();
        exp_q.push_back(mk(7,  3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(9,  3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(11, 3'b111, 1'b1, 1'b0));
        exp_q.push_back(mk(51, 3'b000, 1'b0, 1'b0));
        exp_q.push_back(mk(58, 3'b001, 1'b0, 1'b0));
        exp_q.push_back(mk(60, 3'b011, 1'b0, 1'b0));
        exp_q.push_back(mk(62, 3'b111, 1'b1, 1'b0));
        run_scn("reset_priority", 1'b0, 70, 50, 50, -1, -2);
    endtask

    task automatic test_single_channel();
        do_reset();
        exp_q.push_back(mk(3, 3'b001, 1'b1, 1'b0));
        run_scn("single_channel", 1'b1, 300, -1, -1, -1, -2);
    endtask

    initial begin
        ifa.sw_req   = 1'b0;
        ifa.ext_hold = 1'b0;
        ifb.sw_req   = 1'b0;
        ifb.ext_hold = 1'b0;
        test_reset();
        test_nominal();
        test_ext_hold();
        test_ext_hold_ignored();
        test_sw_req();
        test_reset_priority();
        test_single_channel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of staggered reset channels (1..32).
REQ-002 SHALL have parameter HOLD_CYCLES, default 5: cycles all channels stay in reset after sequence start (>=1).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 2: cycles between consecutive channel releases (>=1).
REQ-004 SHALL have parameter RUN_CYCLES, default 120: run-window length before run_done; 0 = unbounded.
REQ-005 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port sw_req  input  1: single-cycle request to restart the reset sequence.
REQ-008 SHALL have port ext_hold  input  1: while high, freezes the HOLD phase.
REQ-009 SHALL have port ch_reset_n  output  NUM_CH: per-channel active-low reset, registered.
REQ-010 SHALL have port all_released  output  1: all channels out of reset, registered.
REQ-011 SHALL have port run_done  output  1: run window expired, sticky, registered.

Function
REQ-012 SHALL implement FSM states ASSERT, HOLD, RELEASE, RUN, DONE.
REQ-013 SHALL hold state in ASSERT for exactly 1 cycle, then enter HOLD with the counter cleared.
REQ-014 SHALL stay in HOLD for HOLD_CYCLES cycles with ext_hold low; ext_hold high clears the counter and holds it at 0.
REQ-015 SHALL, on entering RELEASE, drive ch_reset_n[0] high on the first RELEASE cycle, then each channel k STAGGER_CYCLES cycles after channel k-1.
REQ-016 SHALL keep released channels high; order is strictly ascending index.
REQ-017 SHALL assert all_released on the same edge as ch_reset_n[NUM_CH-1] rises, and enter RUN on that edge.
REQ-018 SHALL, from any state except ASSERT, move to ASSERT on sw_req; on the next edge all ch_reset_n go low and all_released and run_done clear.
REQ-019 SHALL ignore sw_req while in ASSERT.
REQ-020 SHALL give reset priority over sw_req and ext_hold when they occur in the same cycle.
REQ-021 SHALL ignore ext_hold outside HOLD.
REQ-022 SHALL size counters as $clog2(max(HOLD_CYCLES, STAGGER_CYCLES, RUN_CYCLES)+1) bits, with no wrap-around before the terminal count.

Reset
REQ-023 SHALL, when reset is high, set state ASSERT, ch_reset_n all 0, all_released 0, run_done 0 and counters 0.
REQ-024 SHALL abort any in-progress sequence on reset and restart it from ASSERT on the first edge with reset low.

Configuration
REQ-025 SHALL, with RESET_SEQ_WATCHDOG_EN defined, count RUN cycles and enter DONE with run_done=1 RUN_CYCLES cycles after all_released rises.
REQ-026 SHALL treat RUN_CYCLES=0 as no expiry when RESET_SEQ_WATCHDOG_EN is defined.
REQ-027 SHALL, with RESET_SEQ_WATCHDOG_EN undefined, tie run_done to 0, make RUN terminal (exit only via reset or sw_req), and instantiate no run counter.

Structure
REQ-028 SHALL place the state enum typedef and the counter-width function in package reset_seq_pkg.
REQ-029 SHALL use one sub-module, reset_seq_cnt: loadable counter with enable, clear and terminal-count flag, shared by the HOLD, stagger and run phases.
REQ-030 SHALL flag a parameter error at elaboration if NUM_CH, HOLD_CYCLES or STAGGER_CYCLES is out of range.

Verification
All cycle numbers use default parameters and count from edge 0, the first edge at which reset is sampled low.
REQ-031 SHALL cover the nominal sequence: ASSERT at cycle 1, HOLD cycles 2-6, ch_reset_n = 001 at 7, 011 at 9, 111 at 11, all_released=1 at 11, run_done=1 at 131 (watchdog enabled).
REQ-032 SHALL cover ext_hold high during cycles 4-8: ch_reset_n[0] rises at cycle 14.
REQ-033 SHALL cover sw_req at cycle 10: ch_reset_n = 000 at cycle 11, then the sequence repeats with ch_reset_n[0] high at cycle 17.
REQ-034 SHALL cover reset and sw_req both high at cycle 50: reset behaviour only; after reset drops, the sequence matches the nominal timing.
REQ-035 SHALL cover the build without RESET_SEQ_WATCHDOG_EN: run_done stays 0 through cycle 500 and all_released stays 1.
REQ-036 SHALL cover NUM_CH=1, HOLD_CYCLES=1, RUN_CYCLES=0: ch_reset_n[0] and all_released rise at cycle 3 and run_done never asserts.
